// File: rtl/controle_multiciclo_pkg.sv
// Shared constants and types for the multicycle RV32 control unit.
package controle_multiciclo_pkg;

    // Supported major opcodes (instruction[6:0])
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // Controller states; the encoding is visible on the debug state port
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_ERROR  = 4'd10
    } state_t;

    // ALU operation codes
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_SUB    = 2'b01;
    localparam logic [1:0] ALU_OP_RFUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_IFUNCT = 2'b11;

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS1   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    // Error codes
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Datapath control word produced by the state decode
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // States that hold a memory request open until mem_ready
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Control/handshake bundle between the multicycle controller and its datapath.
interface controle_multiciclo_if #(
    parameter int unsigned INSTRET_W = 32
);
    logic                 run;
    logic [6:0]           opcode;
    logic                 zero;
    logic                 mem_ready;
    logic                 mem_req;
    logic                 mem_we;
    logic                 iord;
    logic                 ir_write;
    logic                 pc_write;
    logic                 pc_src;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           alu_op;
    logic                 busy;
    logic [1:0]           err_code;
    logic [3:0]           state;
    logic [INSTRET_W-1:0] instret;

    // Controller side
    modport master (
        input  run, opcode, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               busy, err_code, state, instret
    );

    // Datapath / environment side
    modport slave (
        output run, opcode, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               busy, err_code, state, instret
    );
endinterface

// File: rtl/controle_multiciclo_contador_timeout.sv
// Memory wait counter: counts consecutive not-ready cycles and flags the
// cycle on which the MEM_TIMEOUT-th one is being spent.
module contador_timeout #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic limit_reached_c
);
    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q;

    // Limit flag: set while the last allowed not-ready cycle is in progress
    generate
        if (MEM_TIMEOUT == 0) begin : g_off
            assign limit_reached_c = 1'b0;
        end else begin : g_on
            assign limit_reached_c = enable && (count_q == CNT_W'(MEM_TIMEOUT - 1));
        end
    endgenerate

    // Counter register; holds at the limit since the FSM leaves on that edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !limit_reached_c) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for RV32 R/I-ALU, lw, sw and beq over a shared
// datapath with a variable-latency unified memory.
module controle_multiciclo
    import controle_multiciclo_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    controle_multiciclo_if.master bus
);

    state_t               state_q;
    state_t               state_d;
    logic [1:0]           err_q;
    logic [1:0]           err_d;
    logic [INSTRET_W-1:0] instret_q;
    logic                 retire_c;
    ctrl_t                ctrl_c;
    logic                 in_mem_c;
    logic                 wait_en_c;
    logic                 wait_clr_c;
    logic                 timeout_c;

    // Wait counter runs only while a memory request is outstanding and not ready
    assign in_mem_c   = is_mem_state(state_q);
    assign wait_en_c  = in_mem_c && !bus.mem_ready;
    assign wait_clr_c = !in_mem_c || bus.mem_ready;

    contador_timeout #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clock           (clock),
        .reset           (reset),
        .clear           (wait_clr_c),
        .enable          (wait_en_c),
        .limit_reached_c (timeout_c)
    );

    // State, error code and retired-instruction registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            err_q     <= ERR_NONE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (retire_c) begin
                instret_q <= instret_q + INSTRET_W'(1);
            end
        end
    end

    // Next-state and control-word decode
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        retire_c = 1'b0;
        ctrl_c   = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.run) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.iord      = 1'b0;
                ctrl_c.alu_src_a = SRC_A_PC;
                ctrl_c.alu_src_b = SRC_B_FOUR;
                ctrl_c.alu_op    = ALU_OP_ADD;
                ctrl_c.ir_write  = bus.mem_ready;
                ctrl_c.pc_write  = bus.mem_ready;
                ctrl_c.pc_src    = 1'b0;
                if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout_c) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end

            ST_DECODE: begin
                // Branch target computed speculatively into ALUOut
                ctrl_c.alu_src_a = SRC_A_OLDPC;
                ctrl_c.alu_src_b = SRC_B_IMM;
                ctrl_c.alu_op    = ALU_OP_ADD;
                case (bus.opcode)
                    OP_R, OP_I:   state_d = ST_EXEC;
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    default: begin
                        state_d = ST_ERROR;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end

            ST_MEMADR: begin
                ctrl_c.alu_src_a = SRC_A_RS1;
                ctrl_c.alu_src_b = SRC_B_IMM;
                ctrl_c.alu_op    = ALU_OP_ADD;
                state_d = (bus.opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end

            ST_MEMRD: begin
                ctrl_c.mem_req = 1'b1;
                ctrl_c.iord    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = ST_MEMWB;
                end else if (timeout_c) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end

            ST_MEMWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                retire_c = 1'b1;
            end

            ST_MEMWR: begin
                ctrl_c.mem_req = 1'b1;
                ctrl_c.mem_we  = 1'b1;
                ctrl_c.iord    = 1'b1;
                if (bus.mem_ready) begin
                    retire_c = 1'b1;
                end else if (timeout_c) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end

            ST_EXEC: begin
                ctrl_c.alu_src_a = SRC_A_RS1;
                if (bus.opcode == OP_I) begin
                    ctrl_c.alu_src_b = SRC_B_IMM;
                    ctrl_c.alu_op    = ALU_OP_IFUNCT;
                end else begin
                    ctrl_c.alu_src_b = SRC_B_RS2;
                    ctrl_c.alu_op    = ALU_OP_RFUNCT;
                end
                state_d = ST_ALUWB;
            end

            ST_ALUWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b0;
                retire_c = 1'b1;
            end

            ST_BRANCH: begin
                ctrl_c.alu_src_a = SRC_A_RS1;
                ctrl_c.alu_src_b = SRC_B_RS2;
                ctrl_c.alu_op    = ALU_OP_SUB;
                ctrl_c.pc_src    = 1'b1;
                ctrl_c.pc_write  = bus.zero;
                retire_c = 1'b1;
            end

            ST_ERROR: begin
                // Trap: only reset leaves this state
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Instruction boundary: run is sampled only here
        if (retire_c) begin
            state_d = bus.run ? ST_FETCH : ST_IDLE;
        end
    end

    // Output mapping
    assign bus.mem_req    = ctrl_c.mem_req;
    assign bus.mem_we     = ctrl_c.mem_we;
    assign bus.iord       = ctrl_c.iord;
    assign bus.ir_write   = ctrl_c.ir_write;
    assign bus.pc_write   = ctrl_c.pc_write;
    assign bus.pc_src     = ctrl_c.pc_src;
    assign bus.reg_write  = ctrl_c.reg_write;
    assign bus.mem_to_reg = ctrl_c.mem_to_reg;
    assign bus.alu_src_a  = ctrl_c.alu_src_a;
    assign bus.alu_src_b  = ctrl_c.alu_src_b;
    assign bus.alu_op     = ctrl_c.alu_op;
    assign bus.busy       = (state_q != ST_IDLE) && (state_q != ST_ERROR);
    assign bus.err_code   = err_q;
    assign bus.state      = state_q;
    assign bus.instret    = instret_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for the multicycle controller: a cycle-by-cycle vector table
// for normal instruction flow plus hand sequences for traps and reset.
module tb_controle_multiciclo;

    localparam logic [6:0] L_R   = 7'b0110011;
    localparam logic [6:0] L_I   = 7'b0010011;
    localparam logic [6:0] L_LW  = 7'b0000011;
    localparam logic [6:0] L_SW  = 7'b0100011;
    localparam logic [6:0] L_BEQ = 7'b1100011;
    localparam logic [6:0] L_BAD = 7'b1111111;

    // {mem_req mem_we iord ir_write pc_write pc_src reg_write mem_to_reg, a, b, op}
    localparam logic [13:0] C_IDLE   = 14'b00000000_00_00_00;
    localparam logic [13:0] C_FETCHR = 14'b10011000_00_01_00;
    localparam logic [13:0] C_FETCHW = 14'b10000000_00_01_00;
    localparam logic [13:0] C_DECODE = 14'b00000000_10_10_00;
    localparam logic [13:0] C_MEMADR = 14'b00000000_01_10_00;
    localparam logic [13:0] C_MEMRD  = 14'b10100000_00_00_00;
    localparam logic [13:0] C_MEMWB  = 14'b00000011_00_00_00;
    localparam logic [13:0] C_MEMWR  = 14'b11100000_00_00_00;
    localparam logic [13:0] C_EXECR  = 14'b00000000_01_00_10;
    localparam logic [13:0] C_EXECI  = 14'b00000000_01_10_11;
    localparam logic [13:0] C_ALUWB  = 14'b00000010_00_00_00;
    localparam logic [13:0] C_BRZ    = 14'b00001100_01_00_01;
    localparam logic [13:0] C_BRNZ   = 14'b00000100_01_00_01;

    logic clock;
    logic reset;
    logic [13:0] ctrl_act;
    int checks;
    int errors;

    typedef struct {
        logic        run;
        logic [6:0]  opcode;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [13:0] ctrl;
        logic        busy;
        logic [1:0]  err;
        logic [31:0] inst;
    } vec_t;

    vec_t tbl[$];

    controle_multiciclo_if #(.INSTRET_W(32)) bus ();

    controle_multiciclo #(
        .MEM_TIMEOUT (4),
        .INSTRET_W   (32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    assign ctrl_act = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
                       bus.pc_src, bus.reg_write, bus.mem_to_reg,
                       bus.alu_src_a, bus.alu_src_b, bus.alu_op};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply inputs for one cycle, check at the falling edge, return at posedge+1
    task automatic step(input string tag, input logic r, input logic [6:0] op,
                        input logic z, input logic rdy, input logic [3:0] st,
                        input logic [13:0] c, input logic b, input logic [1:0] e,
                        input logic [31:0] n);
        bus.run       = r;
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = rdy;
        @(negedge clock);
        chk({tag, " state"},   32'(bus.state),    32'(st));
        chk({tag, " ctrl"},    32'(ctrl_act),     32'(c));
        chk({tag, " busy"},    32'(bus.busy),     32'(b));
        chk({tag, " err"},     32'(bus.err_code), 32'(e));
        chk({tag, " instret"}, bus.instret,       n);
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic r, input logic [6:0] op, input logic z, input logic rdy,
                       input logic [3:0] st, input logic [13:0] c, input logic b,
                       input logic [1:0] e, input logic [31:0] n);
        vec_t t;
        t.run = r; t.opcode = op; t.zero = z; t.rdy = rdy;
        t.st = st; t.ctrl = c; t.busy = b; t.err = e; t.inst = n;
        tbl.push_back(t);
    endtask

    // Async reset mid-cycle: outputs must clear before the next clock edge
    task automatic pulse_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        chk({tag, " rst state"},   32'(bus.state),    32'd0);
        chk({tag, " rst ctrl"},    32'(ctrl_act),     32'd0);
        chk({tag, " rst busy"},    32'(bus.busy),     32'd0);
        chk({tag, " rst err"},     32'(bus.err_code), 32'd0);
        chk({tag, " rst instret"}, bus.instret,       32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.run = 1'b0;
        bus.opcode = 7'd0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;

        // R-type, all ready: FETCH DECODE EXEC ALUWB
        add(1, L_R,   0, 1, 4'd0,  C_IDLE,   0, 2'd0, 0);
        add(1, L_R,   0, 1, 4'd1,  C_FETCHR, 1, 2'd0, 0);
        add(1, L_R,   0, 1, 4'd2,  C_DECODE, 1, 2'd0, 0);
        add(1, L_R,   0, 1, 4'd7,  C_EXECR,  1, 2'd0, 0);
        add(1, L_R,   0, 1, 4'd8,  C_ALUWB,  1, 2'd0, 0);
        // lw with three not-ready cycles in MEMRD: 8 cycles
        add(1, L_LW,  0, 1, 4'd1,  C_FETCHR, 1, 2'd0, 1);
        add(1, L_LW,  0, 1, 4'd2,  C_DECODE, 1, 2'd0, 1);
        add(1, L_LW,  0, 1, 4'd3,  C_MEMADR, 1, 2'd0, 1);
        add(1, L_LW,  0, 0, 4'd4,  C_MEMRD,  1, 2'd0, 1);
        add(1, L_LW,  0, 0, 4'd4,  C_MEMRD,  1, 2'd0, 1);
        add(1, L_LW,  0, 0, 4'd4,  C_MEMRD,  1, 2'd0, 1);
        add(1, L_LW,  0, 1, 4'd4,  C_MEMRD,  1, 2'd0, 1);
        add(1, L_LW,  0, 1, 4'd5,  C_MEMWB,  1, 2'd0, 1);
        // beq taken
        add(1, L_BEQ, 0, 1, 4'd1,  C_FETCHR, 1, 2'd0, 2);
        add(1, L_BEQ, 0, 1, 4'd2,  C_DECODE, 1, 2'd0, 2);
        add(1, L_BEQ, 1, 1, 4'd9,  C_BRZ,    1, 2'd0, 2);
        // beq not taken; zero high outside BRANCH is ignored
        add(1, L_BEQ, 1, 1, 4'd1,  C_FETCHR, 1, 2'd0, 3);
        add(1, L_BEQ, 1, 1, 4'd2,  C_DECODE, 1, 2'd0, 3);
        add(1, L_BEQ, 0, 1, 4'd9,  C_BRNZ,   1, 2'd0, 3);
        // sw with a wait in FETCH and in MEMWR
        add(1, L_SW,  0, 0, 4'd1,  C_FETCHW, 1, 2'd0, 4);
        add(1, L_SW,  0, 1, 4'd1,  C_FETCHR, 1, 2'd0, 4);
        add(1, L_SW,  0, 1, 4'd2,  C_DECODE, 1, 2'd0, 4);
        add(1, L_SW,  0, 1, 4'd3,  C_MEMADR, 1, 2'd0, 4);
        add(1, L_SW,  0, 0, 4'd6,  C_MEMWR,  1, 2'd0, 4);
        add(1, L_SW,  0, 1, 4'd6,  C_MEMWR,  1, 2'd0, 4);
        // I-type, run dropped in EXEC: finishes, then parks in IDLE
        add(1, L_I,   0, 1, 4'd1,  C_FETCHR, 1, 2'd0, 5);
        add(1, L_I,   0, 1, 4'd2,  C_DECODE, 1, 2'd0, 5);
        add(0, L_I,   0, 1, 4'd7,  C_EXECI,  1, 2'd0, 5);
        add(0, L_I,   0, 1, 4'd8,  C_ALUWB,  1, 2'd0, 5);
        add(0, L_I,   0, 1, 4'd0,  C_IDLE,   0, 2'd0, 6);
        add(0, L_I,   0, 1, 4'd0,  C_IDLE,   0, 2'd0, 6);

        repeat (2) @(posedge clock);
        #1;
        chk("reset state",   32'(bus.state),    32'd0);
        chk("reset ctrl",    32'(ctrl_act),     32'd0);
        chk("reset busy",    32'(bus.busy),     32'd0);
        chk("reset err",     32'(bus.err_code), 32'd0);
        chk("reset instret", bus.instret,       32'd0);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("v%0d", i), tbl[i].run, tbl[i].opcode, tbl[i].zero, tbl[i].rdy,
                 tbl[i].st, tbl[i].ctrl, tbl[i].busy, tbl[i].err, tbl[i].inst);
        end

        // Illegal opcode traps after DECODE and ignores run
        step("ill0", 1, L_BAD, 1, 1, 4'd0, C_IDLE,   0, 2'd0, 6);
        step("ill1", 1, L_BAD, 1, 1, 4'd1, C_FETCHR, 1, 2'd0, 6);
        step("ill2", 1, L_BAD, 1, 1, 4'd2, C_DECODE, 1, 2'd0, 6);
        for (int k = 0; k < 20; k++) begin
            step($sformatf("illerr%0d", k), 1, L_BAD, 1, 1, 4'd10, C_IDLE, 0, 2'd1, 6);
        end
        pulse_reset("ill");

        // FETCH timeout after four not-ready cycles
        step("to0", 1, L_R, 0, 0, 4'd0, C_IDLE, 0, 2'd0, 0);
        for (int k = 0; k < 4; k++) begin
            step($sformatf("to_wait%0d", k), 1, L_R, 0, 0, 4'd1, C_FETCHW, 1, 2'd0, 0);
        end
        step("to_err0", 1, L_R, 0, 0, 4'd10, C_IDLE, 0, 2'd2, 0);
        step("to_err1", 1, L_R, 0, 1, 4'd10, C_IDLE, 0, 2'd2, 0);
        pulse_reset("to");

        // mem_ready on the fourth cycle avoids the timeout
        step("nt0", 1, L_R, 0, 0, 4'd0, C_IDLE, 0, 2'd0, 0);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("nt_wait%0d", k), 1, L_R, 0, 0, 4'd1, C_FETCHW, 1, 2'd0, 0);
        end
        step("nt_rdy",  1, L_R, 0, 1, 4'd1, C_FETCHR, 1, 2'd0, 0);
        step("nt_dec",  1, L_R, 0, 1, 4'd2, C_DECODE, 1, 2'd0, 0);
        step("nt_exec", 1, L_R, 0, 1, 4'd7, C_EXECR,  1, 2'd0, 0);
        pulse_reset("nt");

        // Wait counter clears per memory state: 3 waits in FETCH then 3 in MEMRD
        step("wc0", 1, L_LW, 0, 0, 4'd0, C_IDLE, 0, 2'd0, 0);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("wc_f%0d", k), 1, L_LW, 0, 0, 4'd1, C_FETCHW, 1, 2'd0, 0);
        end
        step("wc_frdy", 1, L_LW, 0, 1, 4'd1, C_FETCHR, 1, 2'd0, 0);
        step("wc_dec",  1, L_LW, 0, 1, 4'd2, C_DECODE, 1, 2'd0, 0);
        step("wc_adr",  1, L_LW, 0, 1, 4'd3, C_MEMADR, 1, 2'd0, 0);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("wc_r%0d", k), 1, L_LW, 0, 0, 4'd4, C_MEMRD, 1, 2'd0, 0);
        end
        step("wc_rrdy", 1, L_LW, 0, 1, 4'd4, C_MEMRD,  1, 2'd0, 0);
        step("wc_wb",   0, L_LW, 0, 1, 4'd5, C_MEMWB,  1, 2'd0, 0);
        step("wc_idle", 0, L_LW, 0, 1, 4'd0, C_IDLE,   0, 2'd0, 1);

        // Async reset in the middle of a pending store
        step("ar0", 1, L_SW, 0, 1, 4'd0, C_IDLE,   0, 2'd0, 1);
        step("ar1", 1, L_SW, 0, 1, 4'd1, C_FETCHR, 1, 2'd0, 1);
        step("ar2", 1, L_SW, 0, 1, 4'd2, C_DECODE, 1, 2'd0, 1);
        step("ar3", 1, L_SW, 0, 1, 4'd3, C_MEMADR, 1, 2'd0, 1);
        step("ar4", 1, L_SW, 0, 0, 4'd6, C_MEMWR,  1, 2'd0, 1);
        chk("ar pre mem_we", 32'(bus.mem_we), 32'd1);
        pulse_reset("ar");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Multicycle control FSM for the RV32 subset: R-type, I-type ALU, lw, sw, beq.
- Replaces the single-cycle combinational control unit. It sequences a shared datapath (one ALU, one unified instruction/data memory, register file) over 3-5 cycles per instruction.
- It handshakes with variable-latency memory and detects illegal opcodes and memory timeouts.
- It exposes a retired-instruction counter for benches.

Parameters:
- MEM_TIMEOUT, 16, max wait cycles in a memory state before the error trap; 0 disables the timeout.
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  1 = execute; sampled only at instruction boundaries.
- opcode  in  7  instruction[6:0] from the IR; stable from DECODE until the instruction ends.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request on this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write request (with mem_req).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  1  PC input select: 0 = ALU result, 1 = ALUOut (branch target).
- reg_write  out  1  register file write.
- mem_to_reg  out  1  write-back select: 0 = ALUOut, 1 = MDR.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = rs1, 10 = oldPC.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  2  ALU op: 00 = add, 01 = sub, 10 = R-funct, 11 = I-funct.
- busy  out  1  1 in any state except IDLE and ERROR.
- err_code  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout.
- state  out  4  current state, for debug.
- instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE and all strobes 0.
  - alu selects 00, err_code=00, instret=0, wait counter=0.
  - This takes effect immediately, even in the middle of a memory access.
- Outputs are decoded from state. ir_write and pc_write are additionally gated by mem_ready (FETCH) or zero (BRANCH). Unlisted outputs are 0.
- State encoding:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ERROR=10.
- IDLE: if run=1, go to FETCH.
- FETCH:
  - Outputs: mem_req=1, iord=0, a=00, b=01, alu_op=00.
  - ir_write = pc_write = mem_ready, with pc_src=0.
  - Stay until mem_ready=1, then go to DECODE.
- DECODE:
  - Outputs: a=10, b=10, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 0110011 or 0010011: EXEC.
    - 0000011 or 0100011: MEMADR.
    - 1100011: BRANCH.
    - Any other opcode: ERROR with err_code=01.
- MEMADR:
  - Outputs: a=01, b=10, alu_op=00.
  - lw goes to MEMRD; sw goes to MEMWR.
- MEMRD:
  - Outputs: mem_req=1, iord=1.
  - Go to MEMWB on mem_ready.
- MEMWB:
  - Outputs: reg_write=1, mem_to_reg=1.
  - Instruction boundary.
- MEMWR:
  - Outputs: mem_req=1, mem_we=1, iord=1.
  - The boundary is the mem_ready cycle.
- EXEC:
  - Outputs: a=01.
  - b=00 with alu_op=10 for R-type; b=10 with alu_op=11 for I-type.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: reg_write=1, mem_to_reg=0.
  - Instruction boundary.
- BRANCH:
  - Outputs: a=01, b=00, alu_op=01, pc_src=1.
  - pc_write=zero.
  - Instruction boundary.
- Instruction boundary:
  - instret increments by 1 on the clock edge; it wraps modulo 2^INSTRET_W.
  - Next state is FETCH if run=1, else IDLE.
  - Dropping run mid-instruction always completes that instruction.
- Latency with mem_ready=1 every cycle:
  - R/I-type: 4 cycles. lw: 5. sw: 4. beq: 3.
  - Each cycle mem_ready is low adds exactly 1 cycle.
- Memory states (FETCH, MEMRD, MEMWR):
  - mem_req and address selects are held constant until mem_ready=1.
  - The wait counter clears on entering each memory state.
  - It increments on every cycle in which mem_ready=0.
  - With MEM_TIMEOUT>0, once MEM_TIMEOUT consecutive not-ready cycles have elapsed, the next state is ERROR with err_code=10. mem_ready arriving on the same edge as the timeout wins; no error is raised.
- ERROR:
  - All strobes 0, busy=0. err_code and instret are held.
  - run is ignored. The only exit is reset.
- mem_ready outside memory states is ignored. zero outside BRANCH is ignored.

Decomposition:
- Shared package holds:
  - opcode constants: OP_R, OP_I, OP_LW, OP_SW, OP_BEQ;
  - state encodings;
  - ALU_OP_* codes, SRC_A_*/SRC_B_* select codes and ERR_* codes.
- Sub-module contador_timeout:
  - ports: clear, enable, limit-reached flag;
  - parameterised by MEM_TIMEOUT.
- The FSM next-state and output decode stay in controle_multiciclo.

Test Plan:
- run=1, opcode=0110011, mem_ready=1 → states 1,2,7,8. reg_write=1 only in cycle 4, alu_op=10 in EXEC. instret goes 0→1 after cycle 4.
- run=1, opcode=0000011, mem_ready low for 3 cycles in MEMRD → lw takes 8 cycles. mem_req=1 and iord=1 are stable throughout MEMRD. MEMWB has reg_write=1 and mem_to_reg=1.
- opcode=1100011 → BRANCH with zero=1 gives pc_write=1, pc_src=1. A second run with zero=0 gives pc_write=0. Each run takes 3 cycles and instret increments by 1.
- opcode=1111111 → ERROR after DECODE with err_code=01, busy=0 and all strobes 0 for 20 cycles despite run=1. reset pulse low → IDLE with err_code=00.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH → ERROR with err_code=10 after 4 not-ready cycles. A variant raising mem_ready on the 4th cycle reaches DECODE with no error.
- Async reset=0 mid-MEMWR (mem_we=1) → mem_req=mem_we=0 and state=0 before the next clock edge. Separately, run dropped in EXEC → ALUWB completes, then IDLE, with instret incremented.
